// File: rtl/blank_write_arbiter.sv
// Round-robin arbiter sharing the frame-buffer BRAM write port during video blanking.
// Optional stall statistics enabled by defining BLANK_WRITE_ARB_STATS_EN.
module blank_write_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_WIDTH      = 17,
    parameter int DATA_WIDTH      = 16,
    parameter int BURST_MAX       = 8,
    parameter int GUARD           = 4,
    parameter int ACTIVE_H_PIXELS = 1280,
    parameter int TOTAL_PIXELS    = 1650,
    parameter int ACTIVE_LINES    = 720,
    parameter int TOTAL_LINES     = 750
) (
    input  logic                            clk_pixel_in,
    input  logic                            rst_in,
    input  logic [$clog2(TOTAL_PIXELS)-1:0] hcount_in,
    input  logic [$clog2(TOTAL_LINES)-1:0]  vcount_in,
    input  logic                            nf_in,
    input  logic [NUM_REQ-1:0]              req_valid_in,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_in,
    output logic [NUM_REQ-1:0]              req_ready_out,
    output logic                            bram_we_out,
    output logic [ADDR_WIDTH-1:0]           bram_addr_out,
    output logic [DATA_WIDTH-1:0]           bram_data_out,
    output logic [NUM_REQ-1:0]              grant_out,
    output logic [15:0]                     stall_count_out
);
    localparam int HW = $clog2(TOTAL_PIXELS);
    localparam int VW = $clog2(TOTAL_LINES);
    localparam int OW = $clog2(NUM_REQ);
    localparam logic [HW-1:0] H_OPEN    = HW'(ACTIVE_H_PIXELS);
    localparam logic [HW-1:0] H_CLOSE   = HW'(TOTAL_PIXELS - GUARD);
    localparam logic [VW-1:0] V_OPEN    = VW'(ACTIVE_LINES);
    localparam logic [VW-1:0] V_CLOSE   = VW'(TOTAL_LINES - 1);
    localparam logic [7:0]    BEAT_LAST = 8'(BURST_MAX - 1);
    localparam logic [OW-1:0] LAST_REQ  = OW'(NUM_REQ - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    logic [0:0]    state;
    logic [OW-1:0] owner;
    logic [OW-1:0] rr_ptr;
    logic [7:0]    beat_cnt;

    logic          window;
    logic          own_valid;
    logic          beat_p0;
    logic          pick_found;
    logic [OW-1:0] pick_idx;
    logic [OW-1:0] next_ptr;

    // The read path prefetches the next line, so the horizontal window closes GUARD pixels early.
    assign window = (hcount_in >= H_OPEN && hcount_in < H_CLOSE) ||
                    (vcount_in >= V_OPEN && vcount_in < V_CLOSE);

    assign own_valid = req_valid_in[owner];
    assign beat_p0   = (state == BURST) && own_valid && window;
    assign next_ptr  = (owner == LAST_REQ) ? '0 : owner + OW'(1);

    always_comb begin
        int cand;
        cand       = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!pick_found && req_valid_in[OW'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = OW'(cand);
            end
        end
    end

    always_comb begin
        req_ready_out = '0;
        grant_out     = '0;
        if (state == BURST) begin
            req_ready_out[owner] = window;
            grant_out[owner]     = 1'b1;
        end
    end

    // Stage p0 -> p1: accepted beat becomes the registered BRAM write.
    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            state         <= IDLE;
            owner         <= '0;
            rr_ptr        <= '0;
            beat_cnt      <= '0;
            bram_we_out   <= 1'b0;
            bram_addr_out <= '0;
            bram_data_out <= '0;
        end else begin
            bram_we_out <= beat_p0;
            if (beat_p0) begin
                bram_addr_out <= req_addr_in[int'(owner)*ADDR_WIDTH +: ADDR_WIDTH];
                bram_data_out <= req_data_in[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
            end
            case (state)
                IDLE: begin
                    if (window && pick_found) begin
                        state    <= BURST;
                        owner    <= pick_idx;
                        beat_cnt <= '0;
                    end
                end
                default: begin
                    if (beat_p0) beat_cnt <= beat_cnt + 8'd1;
                    if ((beat_p0 && beat_cnt == BEAT_LAST) || !own_valid || !window) begin
                        state  <= IDLE;
                        rr_ptr <= next_ptr;
                    end
                end
            endcase
        end
    end

`ifdef BLANK_WRITE_ARB_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] stall_cnt_nxt;
    logic [15:0] stall_frame;

    function automatic logic [15:0] sat_inc16(input logic [15:0] val, input logic inc);
        return (inc && val != 16'hFFFF) ? val + 16'd1 : val;
    endfunction

    assign stall_cnt_nxt = sat_inc16(stall_cnt, (|req_valid_in) && !beat_p0);

    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            stall_cnt   <= '0;
            stall_frame <= '0;
        end else if (nf_in) begin
            stall_frame <= stall_cnt_nxt;
            stall_cnt   <= '0;
        end else begin
            stall_cnt <= stall_cnt_nxt;
        end
    end

    assign stall_count_out = stall_frame;
`else
    logic unused_nf;
    assign unused_nf       = nf_in;
    assign stall_count_out = 16'd0;
`endif

endmodule

// File: tb/tb_blank_write_arbiter.sv
// Randomized bench for blank_write_arbiter with a small video geometry and a behavioural model.
module tb_blank_write_arbiter;
    localparam int NR = 4;
    localparam int AW = 17;
    localparam int DW = 16;
    localparam int BM = 5;
    localparam int G  = 4;
    localparam int AH = 40;
    localparam int TP = 56;
    localparam int AL = 6;
    localparam int TL = 10;
    localparam int HW = $clog2(TP);
    localparam int VW = $clog2(TL);
`ifdef BLANK_WRITE_ARB_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_in;
    logic [HW-1:0]     hcount;
    logic [VW-1:0]     vcount;
    logic              nf_in;
    logic [NR-1:0]     req_valid_in;
    logic [NR*AW-1:0]  req_addr_in;
    logic [NR*DW-1:0]  req_data_in;
    logic [NR-1:0]     req_ready_out;
    logic              bram_we_out;
    logic [AW-1:0]     bram_addr_out;
    logic [DW-1:0]     bram_data_out;
    logic [NR-1:0]     grant_out;
    logic [15:0]       stall_count_out;

    always #5 clk = ~clk;

    blank_write_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_MAX(BM), .GUARD(G),
        .ACTIVE_H_PIXELS(AH), .TOTAL_PIXELS(TP), .ACTIVE_LINES(AL), .TOTAL_LINES(TL)
    ) dut (
        .clk_pixel_in(clk), .rst_in(rst_in), .hcount_in(hcount), .vcount_in(vcount),
        .nf_in(nf_in), .req_valid_in(req_valid_in), .req_addr_in(req_addr_in),
        .req_data_in(req_data_in), .req_ready_out(req_ready_out), .bram_we_out(bram_we_out),
        .bram_addr_out(bram_addr_out), .bram_data_out(bram_data_out), .grant_out(grant_out),
        .stall_count_out(stall_count_out)
    );

    // Stimulus state: video position and per-requester beat currently offered.
    int            h = 0;
    int            vl = 0;
    bit            nf = 1'b1;
    bit            rst = 1'b1;
    bit            v[NR];
    logic [AW-1:0] a[NR];
    logic [DW-1:0] d[NR];
    bit            last_acc[NR];
    int            obs_we_h = -1;

    // Reference model state.
    bit            m_busy = 1'b0;
    int            m_owner = 0;
    int            m_ptr = 0;
    int            m_cnt = 0;
    bit            m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    int            m_acc = 0;
    int            m_stall = 0;

    int n_vec = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t h=%0d v=%0d)", tag, got, exp, $time, h, vl);
        end
    endtask

    function automatic bit win_f(input int hh, input int vv);
        return (hh >= AH && hh < TP - G) || (vv >= AL && vv < TL - 1);
    endfunction

    task automatic gen(input int pct, input logic [NR-1:0] mask, input int drop);
        for (int i = 0; i < NR; i++) begin
            if (!mask[i]) v[i] = 1'b0;
            else if (v[i] && !last_acc[i]) begin
                if (int'($urandom_range(99)) < drop) v[i] = 1'b0;
            end else begin
                a[i] = AW'($urandom);
                d[i] = DW'($urandom);
                v[i] = int'($urandom_range(99)) < pct;
            end
        end
    endtask

    task automatic step();
        bit            w;
        bit            beat;
        bit            any;
        logic [NR-1:0] er;
        logic [NR-1:0] eg;
        int            sc;
        @(negedge clk);
        hcount = HW'(h);
        vcount = VW'(vl);
        nf_in  = nf;
        rst_in = rst;
        for (int i = 0; i < NR; i++) begin
            req_valid_in[i]          = v[i];
            req_addr_in[i*AW +: AW]  = a[i];
            req_data_in[i*DW +: DW]  = d[i];
        end
        #1;
        w  = win_f(h, vl);
        er = '0;
        eg = '0;
        if (m_busy) begin
            eg[m_owner] = 1'b1;
            er[m_owner] = w;
        end
        check("ready", 32'(req_ready_out), 32'(er));
        check("grant", 32'(grant_out), 32'(eg));
        check("we", 32'(bram_we_out), 32'(m_we));
        check("addr", 32'(bram_addr_out), 32'(m_addr));
        check("data", 32'(bram_data_out), 32'(m_data));
        check("stall", 32'(stall_count_out), STATS_EN ? 32'(m_stall) : 32'd0);
        if (bram_we_out && obs_we_h < 0) obs_we_h = h;

        any = 1'b0;
        for (int i = 0; i < NR; i++) begin
            any |= v[i];
            last_acc[i] = m_busy && (i == m_owner) && w && v[i];
        end
        beat = m_busy && v[m_owner] && w;

        if (rst) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
            m_we = 0; m_addr = '0; m_data = '0; m_acc = 0; m_stall = 0;
        end else begin
            m_we = beat;
            if (beat) begin
                m_addr = a[m_owner];
                m_data = d[m_owner];
            end
            if (!m_busy) begin
                if (w && any) begin
                    for (int k = NR - 1; k >= 0; k--)
                        if (v[(m_ptr + k) % NR]) m_owner = (m_ptr + k) % NR;
                    m_busy = 1;
                    m_cnt  = 0;
                end
            end else begin
                if (beat) m_cnt++;
                if ((beat && m_cnt == BM) || !v[m_owner] || !w) begin
                    m_busy = 0;
                    m_ptr  = (m_owner + 1) % NR;
                end
            end
            sc = m_acc + ((any && !beat) ? 1 : 0);
            if (sc > 65535) sc = 65535;
            if (nf) begin
                m_stall = sc;
                m_acc   = 0;
            end else m_acc = sc;
        end

        h++;
        if (h == TP) begin
            h = 0;
            vl++;
            if (vl == TL) vl = 0;
        end
        nf = (h == 0 && vl == 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pcts[4] = '{90, 50, 20, 100};
        bit hit;
        bit got;
        int tally;
        bit any;

        for (int i = 0; i < NR; i++) begin
            v[i] = 1'b1; a[i] = AW'($urandom); d[i] = DW'($urandom); last_acc[i] = 1'b0;
        end
        rst_in = 1'b1; nf_in = 1'b0; hcount = '0; vcount = '0;
        req_valid_in = '1; req_addr_in = '0; req_data_in = '0;
        @(posedge clk);

        // Reset held three cycles with every requester valid.
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // Random traffic over several frames at varying request densities.
        for (int f = 0; f < 4; f++)
            for (int n = 0; n < TP * TL; n++) begin
                gen(pcts[f], 4'hF, 5);
                step();
            end

        // Requester 0 alone from the top of a frame: first write two cycles after window opens.
        for (int n = 0; n < TP * TL && !(h == 0 && vl == 0); n++) begin
            gen(0, 4'h0, 0);
            step();
        end
        obs_we_h = -1;
        for (int n = 0; n < TP * TL; n++) begin
            gen(100, 4'h1, 0);
            step();
        end
        check("first_we_h", 32'(obs_we_h), 32'(AH + 2));

        // Requester 1 alone for whole frames; stall count reported after each new-frame pulse.
        for (int n = 0; n < TP * TL && !(h == 0 && vl == 0); n++) begin
            gen(0, 4'h0, 0);
            step();
        end
        for (int fr = 0; fr < 2; fr++) begin
            gen(100, 4'h2, 0);
            step();
            tally = 0;
            for (int n = 0; n < TP * TL; n++) begin
                gen(100, 4'h2, 0);
                step();
                any = 1'b0;
                for (int i = 0; i < NR; i++) any |= v[i];
                if (any && !last_acc[0] && !last_acc[1] && !last_acc[2] && !last_acc[3]) tally++;
            end
            gen(100, 4'h2, 0);
            step();
            check("stall_frame", 32'(stall_count_out), STATS_EN ? 32'(tally) : 32'd0);
        end

        // Reset on the fourth beat of a burst, then first grant must go to requester 0.
        hit = 1'b0;
        for (int n = 0; n < 1000 && !hit; n++) begin
            gen(100, 4'hF, 0);
            if (m_busy && m_cnt == 3 && v[m_owner] && win_f(h, vl)) begin
                rst = 1'b1;
                hit = 1'b1;
            end
            step();
        end
        rst = 1'b0;
        check("rst_mid_burst_hit", 32'(hit), 32'd1);
        gen(100, 4'hF, 0);
        step();
        check("rst_beat_dropped_we", 32'(bram_we_out), 32'd0);
        got = 1'b0;
        for (int n = 0; n < 1000 && !got; n++) begin
            gen(100, 4'hF, 0);
            step();
            if (grant_out != '0) got = 1'b1;
        end
        check("regrant_owner", 32'(grant_out), 32'd1);

        for (int n = 0; n < 200; n++) begin
            gen(60, 4'hF, 10);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/blank_write_arbiter.md
# blank_write_arbiter

Shares the single write port of the display frame-buffer BRAM among NUM_REQ write requesters (sprite blitter, text overlay, camera ingest, …), granting access only inside the blanking window derived from the video timing counters. Sits beside the video timing generator in the pixel clock domain; the display read path owns the BRAM during active video and never sees a write. Arbitration is round-robin with bounded bursts so no requester starves within a frame.

## Interface
- NUM_REQ, 4, number of write requesters (2..8)
- ADDR_WIDTH, 17, BRAM address width
- DATA_WIDTH, 16, BRAM data width
- BURST_MAX, 8, max beats per grant (1..255)
- GUARD, 4, pixels before end of line where the window closes (read-path prefetch)
- ACTIVE_H_PIXELS, 1280; TOTAL_PIXELS, 1650; ACTIVE_LINES, 720; TOTAL_LINES, 750: timing geometry
- clk_pixel_in  in  1  pixel clock; only clock
- rst_in  in  1  synchronous, active-high reset
- hcount_in  in  $clog2(TOTAL_PIXELS)  current pixel column from timing generator
- vcount_in  in  $clog2(TOTAL_LINES)  current line
- nf_in  in  1  new-frame pulse, one cycle
- req_valid_in  in  NUM_REQ  per-requester beat valid
- req_addr_in  in  NUM_REQ*ADDR_WIDTH  flattened addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data_in  in  NUM_REQ*DATA_WIDTH  flattened data, same packing
- req_ready_out  out  NUM_REQ  per-requester beat accept
- bram_we_out  out  1  BRAM write enable
- bram_addr_out  out  ADDR_WIDTH  BRAM write address
- bram_data_out  out  DATA_WIDTH  BRAM write data
- grant_out  out  NUM_REQ  one-hot current owner, zero when IDLE
- stall_count_out  out  16  previous-frame stall cycles (see Configuration)

## Operation
- window (combinational) = (hcount_in >= ACTIVE_H_PIXELS && hcount_in < TOTAL_PIXELS-GUARD) || (vcount_in >= ACTIVE_LINES && vcount_in < TOTAL_LINES-1).
- States IDLE, BURST. Registers: state, owner, rr_ptr, beat_cnt (8 bit).
- IDLE: if window and any req_valid_in, pick first valid index scanning rr_ptr, rr_ptr+1, … mod NUM_REQ; next cycle state=BURST, owner=that index, beat_cnt=0. No ready in IDLE.
- BURST: req_ready_out[owner] = window (combinational); all other readies 0. Beat transfers when valid && ready; beat_cnt increments.
- BURST exits to IDLE at the clock edge when: accepted beat makes beat_cnt==BURST_MAX, or owner's valid is low, or window is low. On exit rr_ptr = (owner+1) mod NUM_REQ.
- Simultaneous window close and valid: no beat transfers; burst ends.
- Writes issued only for accepted beats; no dropped or duplicated beats. Requester must hold addr/data stable while valid && !ready.
- grant_out = one-hot(owner) in BURST, 0 in IDLE.

## Timing
- Reset: state=IDLE, rr_ptr=0, owner=0, beat_cnt=0; all outputs 0 the cycle after rst_in sampled high. Reset mid-burst aborts burst; the beat accepted on the reset cycle is not written.
- Grant latency: 1 cycle from IDLE with valid to first possible ready.
- Write latency: bram_we_out/addr/data registered, asserted the cycle after the beat is accepted; addr/data hold last value when we low.
- At least one IDLE cycle between consecutive bursts; max throughput BURST_MAX beats per BURST_MAX+1 cycles.
- Last possible write strobe of a line lands at hcount TOTAL_PIXELS-GUARD; none during active video.

## Configuration
- BLANK_WRITE_ARB_STATS_EN defined: 16-bit counter increments each cycle any req_valid_in is high and no beat transfers; saturates at 16'hFFFF. On nf_in, stall_count_out <= counter (including current cycle's increment), counter cleared. Both reset to 0.
- Not defined: counter absent, stall_count_out tied 0.

## Test plan
- Reset: hold rst_in 3 cycles with all valids high -> all outputs 0, no ready, first grant only after release.
- Single requester 0 valid from line 0 hcount 1280 -> ready at hcount 1281–1288 (8 beats), bram_we_out at 1282–1289 with matching addr/data, idle at 1289, regrant at 1290.
- All 4 valid throughout vertical blank -> owners 0,1,2,3,0… each exactly 8 beats, grant_out one-hot, one idle cycle between bursts.
- Requester 2 valid from hcount 1640 on line 5 -> beats at 1641–1645 only, no ready at 1646–1649 nor during line 6 active pixels, resumes at line 6 hcount 1281 (after regrant).
- rst_in asserted at 4th beat of a burst -> no write for that beat, next grant starts from requester 0.
- STATS_EN: requester 1 valid for every cycle of a frame with no others -> stall_count_out after nf_in equals cycles outside beats, exact count checked against model; cleared counter restarts at 0.
